// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode definitions: FSM state encoding, the NOP word,
// the two-word flag position and the IF/ID record handed to decode.
package fetch_unit_pkg;

  localparam int unsigned PC_W_DEF    = 32;
  localparam int unsigned INSTR_W_DEF = 16;

  typedef enum logic {
    S_OP  = 1'b0,
    S_IMM = 1'b1
  } fetch_state_t;

  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = '0;

  // Bit of an opcode word that marks a following immediate word (the MSB).
  localparam int unsigned TWO_WORD_BIT = INSTR_W_DEF - 1;

  typedef struct packed {
    logic [INSTR_W_DEF-1:0] instr;
    logic [INSTR_W_DEF-1:0] imm;
    logic [PC_W_DEF-1:0]    pc;
    logic                   valid;
  } ifid_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter: reset vector, redirect on flush, word increment.
module pc_reg
  import fetch_unit_pkg::*;
#(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_write_i,
  input  logic            flush_i,
  input  logic [PC_W-1:0] target_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  // Redirect wins over increment; increment wraps naturally at 2^PC_W.
  always_comb begin
    pc_d = pc_q;
    if (flush_i) begin
      pc_d = target_i;
    end else if (pc_write_i) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  // PC register, loaded with the reset vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage and IF/ID register: assembles one- or two-word instructions
// and honours branch flushes and load-use stalls.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned     PC_W     = 32,
  parameter int unsigned     INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pc_write,
  input  logic               stall_fetch,
  input  logic               flush_fetch,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [INSTR_W-1:0] ifid_imm,
  output logic [PC_W-1:0]    ifid_pc,
  output logic               ifid_valid
);

  logic [PC_W-1:0]    pc;
  fetch_state_t       state_q;
  logic [INSTR_W-1:0] hold_op_q;
  logic [PC_W-1:0]    hold_pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic [INSTR_W-1:0] imm_q;
  logic [PC_W-1:0]    ifid_pc_q;
  logic               valid_q;
  logic               two_word;

  pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .rst        (rst),
    .pc_write_i (pc_write),
    .flush_i    (flush_fetch),
    .target_i   (branch_target),
    .pc_o       (pc)
  );

  assign imem_addr = pc;
  // The flag sits in the MSB of the opcode word for any INSTR_W.
  assign two_word  = imem_data[INSTR_W-1];

  // Fetch FSM and IF/ID register; flush beats stall, stall freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_OP;
      hold_op_q <= '0;
      hold_pc_q <= '0;
      instr_q   <= INSTR_W'(NOP_INSTR);
      imm_q     <= '0;
      ifid_pc_q <= '0;
      valid_q   <= 1'b0;
    end else if (flush_fetch) begin
      // Any half-assembled instruction is dropped here.
      state_q <= S_OP;
      instr_q <= INSTR_W'(NOP_INSTR);
      imm_q   <= '0;
      valid_q <= 1'b0;
    end else if (!stall_fetch) begin
      case (state_q)
        S_OP: begin
          if (two_word) begin
            hold_op_q <= imem_data;
            hold_pc_q <= pc;
            instr_q   <= INSTR_W'(NOP_INSTR);
            imm_q     <= '0;
            valid_q   <= 1'b0;
            state_q   <= S_IMM;
          end else begin
            instr_q   <= imem_data;
            imm_q     <= '0;
            ifid_pc_q <= pc;
            valid_q   <= 1'b1;
          end
        end
        S_IMM: begin
          // The immediate word is taken verbatim, its MSB is not a flag.
          instr_q   <= hold_op_q;
          imm_q     <= imem_data;
          ifid_pc_q <= hold_pc_q;
          valid_q   <= 1'b1;
          state_q   <= S_OP;
        end
        default: begin
          state_q <= S_OP;
        end
      endcase
    end
  end

  assign ifid_instr = instr_q;
  assign ifid_imm   = imm_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle-accurate scoreboard of IF/ID contents.
module tb_fetch_unit;

  typedef struct {
    logic        v;
    logic [15:0] instr;
    logic [15:0] imm;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write;
  logic        stall_fetch;
  logic        flush_fetch;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_imm;
  logic [31:0] ifid_pc;
  logic        ifid_valid;

  // Narrow instance for the PC wrap case.
  logic [3:0]  imem_addr4;
  logic [15:0] ifid_instr4;
  logic [15:0] ifid_imm4;
  logic [3:0]  ifid_pc4;
  logic        ifid_valid4;

  logic [15:0] mem [0:255];
  exp_t        sb[$];
  exp_t        last_e;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[7:0]];

  fetch_unit #(.PC_W(32), .INSTR_W(16), .RESET_PC(32'd0)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_write      (pc_write),
    .stall_fetch   (stall_fetch),
    .flush_fetch   (flush_fetch),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .ifid_instr    (ifid_instr),
    .ifid_imm      (ifid_imm),
    .ifid_pc       (ifid_pc),
    .ifid_valid    (ifid_valid)
  );

  fetch_unit #(.PC_W(4), .INSTR_W(16), .RESET_PC(4'd15)) dut4 (
    .clk           (clk),
    .rst           (rst),
    .pc_write      (1'b1),
    .stall_fetch   (1'b0),
    .flush_fetch   (1'b0),
    .branch_target (4'd0),
    .imem_addr     (imem_addr4),
    .imem_data     (16'h0042),
    .ifid_instr    (ifid_instr4),
    .ifid_imm      (ifid_imm4),
    .ifid_pc       (ifid_pc4),
    .ifid_valid    (ifid_valid4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock edge; unstalled edges pop the next expected IF/ID state,
  // stalled edges expect the previous state to be held.
  task automatic tick(input bit stalled);
    exp_t e;
    @(posedge clk);
    #1;
    if (stalled) begin
      e = last_e;
    end else begin
      if (sb.size() == 0) begin
        $display("FAIL scoreboard_underflow got=empty exp=entry");
        $fatal(1, "scoreboard underflow");
      end
      e = sb.pop_front();
      last_e = e;
    end
    check("valid", 32'(ifid_valid), 32'(e.v));
    check("instr", 32'(ifid_instr), 32'(e.instr));
    check("imm", 32'(ifid_imm), 32'(e.imm));
    if (e.v) check("pc", ifid_pc, e.pc);
  endtask

  task automatic step(input logic v, input logic [15:0] instr,
                      input logic [15:0] imm, input logic [31:0] pc);
    exp_t e;
    e.v = v; e.instr = instr; e.imm = imm; e.pc = pc;
    sb.push_back(e);
    tick(1'b0);
  endtask

  task automatic bubble();
    step(1'b0, 16'h0000, 16'h0000, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i);
    mem[0]    = 16'h1234;
    mem[4]    = 16'h8005;
    mem[5]    = 16'hBEEF;
    mem[10]   = 16'h9001;
    mem[11]   = 16'hC00B;
    mem[12]   = 16'h8123;
    mem[8'h81] = 16'h8777;

    rst = 1'b1; pc_write = 1'b1; stall_fetch = 1'b0;
    flush_fetch = 1'b0; branch_target = 32'h0;
    last_e = '{v: 1'b0, instr: 16'h0, imm: 16'h0, pc: 32'h0};
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(ifid_valid), 32'd0);
    check("rst_instr", 32'(ifid_instr), 32'd0);
    check("rst_pc", ifid_pc, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_addr4", 32'(imem_addr4), 32'd15);
    rst = 1'b0;

    // Straight-line one-word fetches, then a two-word instruction at 4.
    step(1'b1, 16'h1234, 16'h0, 32'd0);
    check("wrap_addr4", 32'(imem_addr4), 32'd0);
    check("wrap_pc4", 32'(ifid_pc4), 32'd15);
    check("wrap_instr4", 32'(ifid_instr4), 32'h0042);
    step(1'b1, 16'h0001, 16'h0, 32'd1);
    step(1'b1, 16'h0002, 16'h0, 32'd2);
    step(1'b1, 16'h0003, 16'h0, 32'd3);
    bubble();
    step(1'b1, 16'h8005, 16'hBEEF, 32'd4);
    check("addr_after_2w", imem_addr, 32'd6);
    step(1'b1, 16'h0006, 16'h0, 32'd6);
    step(1'b1, 16'h0007, 16'h0, 32'd7);

    // Two stalled cycles with IF/ID holding pc=7.
    stall_fetch = 1'b1; pc_write = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick(1'b1);
      check("stall_addr", imem_addr, 32'd8);
    end
    stall_fetch = 1'b0; pc_write = 1'b1;
    step(1'b1, 16'h0008, 16'h0, 32'd8);
    step(1'b1, 16'h0009, 16'h0, 32'd9);

    // Opcode at 10, stall while waiting for the immediate at 11.
    bubble();
    stall_fetch = 1'b1; pc_write = 1'b0;
    tick(1'b1);
    check("imm_stall_addr", imem_addr, 32'd11);
    stall_fetch = 1'b0; pc_write = 1'b1;
    step(1'b1, 16'h9001, 16'hC00B, 32'd10);

    // Flush together with stall while in S_IMM.
    bubble();
    flush_fetch = 1'b1; stall_fetch = 1'b1; pc_write = 1'b0;
    branch_target = 32'h40;
    bubble();
    check("flush_addr", imem_addr, 32'h40);
    flush_fetch = 1'b0; stall_fetch = 1'b0; pc_write = 1'b1;
    step(1'b1, 16'h0040, 16'h0, 32'h40);

    // Flush from S_OP discards a valid output.
    flush_fetch = 1'b1; branch_target = 32'h80;
    bubble();
    check("flush2_addr", imem_addr, 32'h80);
    flush_fetch = 1'b0;
    step(1'b1, 16'h0080, 16'h0, 32'h80);

    // Asynchronous reset in the middle of a two-word instruction.
    bubble();
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(ifid_valid), 32'd0);
    check("arst_instr", 32'(ifid_instr), 32'd0);
    check("arst_pc", ifid_pc, 32'd0);
    check("arst_addr", imem_addr, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(1'b1, 16'h1234, 16'h0, 32'd0);
    step(1'b1, 16'h0001, 16'h0, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
